// File: rtl/vga_pkg.sv
// Shared VGA-domain constants, scheduler state encoding and config clamp helpers.
package vga_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned COL_W     = 10;
    localparam int unsigned SPAN_W    = COL_W + 1;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } sched_state_t;

    // Force a requested width into [1, H_VISIBLE].
    function automatic logic [SPAN_W-1:0] clamp_width(input logic [COL_W-1:0] w);
        if (w == '0) begin
            return SPAN_W'(1);
        end else if (SPAN_W'(w) > SPAN_W'(H_VISIBLE)) begin
            return SPAN_W'(H_VISIBLE);
        end else begin
            return SPAN_W'(w);
        end
    endfunction

    // Pull a requested start back so the span ends inside the visible line.
    function automatic logic [COL_W-1:0] clamp_start(input logic [COL_W-1:0]  s,
                                                     input logic [SPAN_W-1:0] w);
        logic [SPAN_W-1:0] lim;
        lim = SPAN_W'(H_VISIBLE) - w;
        if (SPAN_W'(s) > lim) begin
            return COL_W'(lim);
        end else begin
            return s;
        end
    endfunction

endpackage

// File: rtl/plataform_step.sv
// Bounce arithmetic: next start column and direction for one movement event.
//   start         - current left column
//   width         - current span width (1..H_VISIBLE)
//   moving_right  - current direction
//   next_start_c  - start after the move (combinational)
//   next_right_c  - direction after the move (combinational)
module plataform_step
    import vga_pkg::*;
#(
    parameter int unsigned STEP = 2
) (
    input  logic [COL_W-1:0]  start,
    input  logic [SPAN_W-1:0] width,
    input  logic              moving_right,
    output logic [COL_W-1:0]  next_start_c,
    output logic              next_right_c
);

    logic [SPAN_W-1:0] limit;
    logic [SPAN_W-1:0] sum;

    assign limit = SPAN_W'(H_VISIBLE) - width;
    assign sum   = SPAN_W'(start) + SPAN_W'(STEP);

    // Hitting either wall pins the span to that wall and reverses direction.
    always_comb begin
        next_start_c = start;
        next_right_c = moving_right;
        if (moving_right) begin
            if (sum >= limit) begin
                next_start_c = COL_W'(limit);
                next_right_c = 1'b0;
            end else begin
                next_start_c = COL_W'(sum);
            end
        end else begin
            if (SPAN_W'(start) <= SPAN_W'(STEP)) begin
                next_start_c = '0;
                next_right_c = 1'b1;
            end else begin
                next_start_c = start - COL_W'(STEP);
            end
        end
    end

endmodule

// File: rtl/plataform_scheduler.sv
// Moving-platform scheduler: owns the live platform span, bounces it every
// FRAME_DIV frame ticks and commits game-logic configs on the frame tick only.
//   clk             - vga pixel clock
//   reset           - asynchronous active-low reset
//   frame_tick      - one-cycle pulse at start of vertical blank
//   enable          - movement enable, sampled on frame_tick
//   cfg_valid/ready - config handshake; cfg_start/cfg_width are the request
//   plataform_start - current left column
//   plataform_end   - current right column (inclusive)
//   moving_right    - current direction
module plataform_scheduler
    import vga_pkg::*;
#(
    parameter int unsigned STEP       = 2,
    parameter int unsigned FRAME_DIV  = 2,
    parameter int unsigned INIT_START = 200,
    parameter int unsigned INIT_WIDTH = 120
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [COL_W-1:0] cfg_start,
    input  logic [COL_W-1:0] cfg_width,
    output logic             cfg_ready,
    output logic [COL_W-1:0] plataform_start,
    output logic [COL_W-1:0] plataform_end,
    output logic             moving_right
);

    localparam int unsigned DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    sched_state_t      state;
    logic [SPAN_W-1:0] width_q;
    logic [COL_W-1:0]  shadow_start;
    logic [SPAN_W-1:0] shadow_width;
    logic [DIV_W-1:0]  div_q;

    logic [COL_W-1:0]  step_start_c;
    logic              step_right_c;
    logic [SPAN_W-1:0] cfg_width_c;
    logic [COL_W-1:0]  cfg_start_c;
    logic [COL_W-1:0]  step_end_c;
    logic [COL_W-1:0]  shadow_end_c;

    plataform_step #(
        .STEP (STEP)
    ) u_step (
        .start        (plataform_start),
        .width        (width_q),
        .moving_right (moving_right),
        .next_start_c (step_start_c),
        .next_right_c (step_right_c)
    );

    // Clamp the incoming request so shadow registers always hold a legal span.
    assign cfg_width_c  = clamp_width(cfg_width);
    assign cfg_start_c  = clamp_start(cfg_start, cfg_width_c);

    assign step_end_c   = COL_W'(SPAN_W'(step_start_c) + width_q - SPAN_W'(1));
    assign shadow_end_c = COL_W'(SPAN_W'(shadow_start) + shadow_width - SPAN_W'(1));

    // FSM, divider, shadow and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            cfg_ready       <= 1'b1;
            div_q           <= '0;
            width_q         <= SPAN_W'(INIT_WIDTH);
            shadow_start    <= '0;
            shadow_width    <= SPAN_W'(1);
            plataform_start <= COL_W'(INIT_START);
            plataform_end   <= COL_W'(INIT_START + INIT_WIDTH - 1);
            moving_right    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_tick && enable) begin
                        if (div_q == DIV_W'(FRAME_DIV - 1)) begin
                            div_q           <= '0;
                            plataform_start <= step_start_c;
                            plataform_end   <= step_end_c;
                            moving_right    <= step_right_c;
                        end else begin
                            div_q <= div_q + DIV_W'(1);
                        end
                    end
                    // cfg_ready is high throughout IDLE, so valid alone is a transfer.
                    if (cfg_valid) begin
                        shadow_start <= cfg_start_c;
                        shadow_width <= cfg_width_c;
                        cfg_ready    <= 1'b0;
                        state        <= PENDING;
                    end
                end
                PENDING: begin
                    // Commit wins over movement for this frame.
                    if (frame_tick) begin
                        plataform_start <= shadow_start;
                        plataform_end   <= shadow_end_c;
                        width_q         <= shadow_width;
                        div_q           <= '0;
                        cfg_ready       <= 1'b1;
                        state           <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plataform_scheduler.sv
// Scoreboard bench for plataform_scheduler: a reference model pushes the
// expected registered outputs each cycle, popped and compared after the edge.
module tb_plataform_scheduler;

    localparam int HV     = 640;
    localparam int STEP   = 2;
    localparam int FD     = 2;
    localparam int ISTART = 200;
    localparam int IWIDTH = 120;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       enable;
    logic       cfg_valid;
    logic [9:0] cfg_start;
    logic [9:0] cfg_width;
    logic       cfg_ready;
    logic [9:0] plataform_start;
    logic [9:0] plataform_end;
    logic       moving_right;

    plataform_scheduler #(
        .STEP       (STEP),
        .FRAME_DIV  (FD),
        .INIT_START (ISTART),
        .INIT_WIDTH (IWIDTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .frame_tick      (frame_tick),
        .enable          (enable),
        .cfg_valid       (cfg_valid),
        .cfg_start       (cfg_start),
        .cfg_width       (cfg_width),
        .cfg_ready       (cfg_ready),
        .plataform_start (plataform_start),
        .plataform_end   (plataform_end),
        .moving_right    (moving_right)
    );

    always #5 clk = ~clk;

    typedef struct {
        int s;
        int e;
        int r;
        int rdy;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_start, m_width, m_right, m_div, m_pend, sh_s, sh_w;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_start = ISTART;
        m_width = IWIDTH;
        m_right = 1;
        m_div   = 0;
        m_pend  = 0;
        sh_s    = 0;
        sh_w    = 1;
    endfunction

    function automatic void model_move();
        int lim;
        lim = HV - m_width;
        if (m_right == 1) begin
            if (m_start + STEP >= lim) begin
                m_start = lim;
                m_right = 0;
            end else begin
                m_start = m_start + STEP;
            end
        end else begin
            if (m_start <= STEP) begin
                m_start = 0;
                m_right = 1;
            end else begin
                m_start = m_start - STEP;
            end
        end
    endfunction

    // One clock cycle: drive inputs, advance the model, compare after the edge.
    task automatic cyc(input logic ft, input logic en, input logic cv,
                       input int cs, input int cw);
        exp_t x;
        int   w;
        @(negedge clk);
        frame_tick = ft;
        enable     = en;
        cfg_valid  = cv;
        cfg_start  = 10'(cs);
        cfg_width  = 10'(cw);
        if (m_pend == 1) begin
            if (ft) begin
                m_start = sh_s;
                m_width = sh_w;
                m_div   = 0;
                m_pend  = 0;
            end
        end else begin
            if (ft && en) begin
                if (m_div == FD - 1) begin
                    m_div = 0;
                    model_move();
                end else begin
                    m_div++;
                end
            end
            if (cv) begin
                w    = (cw == 0) ? 1 : ((cw > HV) ? HV : cw);
                sh_w = w;
                sh_s = (cs > HV - w) ? HV - w : cs;
                m_pend = 1;
            end
        end
        x.s   = m_start;
        x.e   = m_start + m_width - 1;
        x.r   = m_right;
        x.rdy = (m_pend == 1) ? 0 : 1;
        sb.push_back(x);
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        cfg_valid  = 1'b0;
        x = sb.pop_front();
        check("start", 32'(plataform_start), 32'(x.s));
        check("end",   32'(plataform_end),   32'(x.e));
        check("right", 32'(moving_right),    32'(x.r));
        check("ready", 32'(cfg_ready),       32'(x.rdy));
    endtask

    task automatic tick(input logic en);
        cyc(1'b1, en, 1'b0, 0, 0);
        cyc(1'b0, en, 1'b0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"}, 32'(plataform_start), 32'(ISTART));
        check({tag, "_end"},   32'(plataform_end),   32'(ISTART + IWIDTH - 1));
        check({tag, "_right"}, 32'(moving_right),    32'd1);
        check({tag, "_ready"}, 32'(cfg_ready),       32'd1);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        sb.delete();
    endtask

    initial begin
        reset      = 1'b0;
        frame_tick = 1'b0;
        enable     = 1'b0;
        cfg_valid  = 1'b0;
        cfg_start  = '0;
        cfg_width  = '0;
        #12;
        check_reset_outputs("por");
        release_reset();

        // Defaults moving: 4 ticks = 2 movement events
        for (int i = 0; i < 4; i++) tick(1'b1);
        check("t2_start", 32'(plataform_start), 32'd204);
        check("t2_end",   32'(plataform_end),   32'd323);
        for (int i = 0; i < 4; i++) tick(1'b0);
        check("t2_hold", 32'(plataform_start), 32'd204);

        // Async reset mid-run, checked without a clock edge
        tick(1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("async");
        release_reset();

        // Right-wall bounce
        cyc(1'b0, 1'b1, 1'b1, 518, 120);
        check("t3_rdy0", 32'(cfg_ready), 32'd0);
        tick(1'b1);
        check("t3_commit", 32'(plataform_start), 32'd518);
        tick(1'b1);
        tick(1'b1);
        check("t3_wall_s", 32'(plataform_start), 32'd520);
        check("t3_wall_e", 32'(plataform_end),   32'd639);
        check("t3_wall_r", 32'(moving_right),    32'd0);
        tick(1'b1);
        tick(1'b1);
        check("t3_back", 32'(plataform_start), 32'd518);

        // Oversized config clamps to full line
        cyc(1'b0, 1'b1, 1'b1, 600, 700);
        tick(1'b1);
        check("t4_s", 32'(plataform_start), 32'd0);
        check("t4_e", 32'(plataform_end),   32'd639);
        for (int i = 0; i < 4; i++) tick(1'b1);
        check("t4_keep_s", 32'(plataform_start), 32'd0);
        check("t4_keep_e", 32'(plataform_end),   32'd639);

        // Handshake without tick; second request ignored
        cyc(1'b0, 1'b1, 1'b1, 300, 100);
        cyc(1'b0, 1'b1, 1'b1, 100, 50);
        check("t5_unch", 32'(plataform_start), 32'd0);
        check("t5_rdy0", 32'(cfg_ready), 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 0, 0);
        check("t5_commit_s", 32'(plataform_start), 32'd300);
        check("t5_commit_e", 32'(plataform_end),   32'd399);
        check("t5_rdy1",     32'(cfg_ready),       32'd1);
        // cfg coincident with the movement tick
        cyc(1'b1, 1'b1, 1'b0, 0, 0);
        cyc(1'b1, 1'b1, 1'b1, 10, 20);
        check("t5_move", 32'(plataform_start), 32'd298);
        check("t5_pend", 32'(cfg_ready), 32'd0);
        tick(1'b1);
        check("t5_late_s", 32'(plataform_start), 32'd10);
        check("t5_late_e", 32'(plataform_end),   32'd29);

        // Zero width request becomes one pixel
        cyc(1'b0, 1'b1, 1'b1, 639, 0);
        tick(1'b1);
        check("w0_s", 32'(plataform_start), 32'd639);
        check("w0_e", 32'(plataform_end),   32'd639);

        // Reset while pending drops the config
        cyc(1'b0, 1'b1, 1'b1, 400, 50);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("t6");
        release_reset();
        tick(1'b1);
        tick(1'b1);
        check("t6_noold", 32'(plataform_start), 32'd202);
        check("t6_sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
